// File: rtl/serial_frame_rx.sv
// Receive-side deframer for the PPP-style serial link: strips flags and escapes,
// checks the trailing 8-bit checksum and streams payload with one-byte holdback.
module serial_frame_rx #(
  parameter int MAX_LEN = 64
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_strobe,
  output logic [7:0] out_data,
  output logic       out_strobe,
  output logic       out_first,
  output logic       frame_done,
  output logic       frame_error,
  output logic [7:0] frame_len
);

  typedef enum logic [1:0] {HUNT, START, DATA} state_e;

  localparam logic [7:0] FLAG  = 8'h7E;
  localparam logic [7:0] ESC   = 8'h7D;
  localparam logic [7:0] LIMIT = 8'(MAX_LEN + 1);

  state_e     state_q, state_d;
  logic       esc_q, esc_d;
  logic [7:0] held_q, held_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] count_q, count_d;

  logic [7:0] out_data_q, out_data_d;
  logic       out_strobe_q, out_strobe_d;
  logic       out_first_q, out_first_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_error_q, frame_error_d;
  logic [7:0] frame_len_q, frame_len_d;

  logic       is_flag, is_esc, is_data;
  logic [7:0] dec;

  // An ESC that arrives while esc is already set is escaped data, not a new escape.
  always_comb begin
    is_flag = in_strobe && (in_data == FLAG);
    is_esc  = in_strobe && (in_data == ESC) && !esc_q;
    is_data = in_strobe && !is_flag && !is_esc;
    dec     = esc_q ? (in_data ^ 8'h20) : in_data;
  end

  // NOTE: state and outputs use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q       <= HUNT;
      esc_q         <= 1'b0;
      held_q        <= 8'h00;
      sum_q         <= 8'h00;
      count_q       <= 8'h00;
      out_data_q    <= 8'h00;
      out_strobe_q  <= 1'b0;
      out_first_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      frame_len_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      esc_q         <= esc_d;
      held_q        <= held_d;
      sum_q         <= sum_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_strobe_q  <= out_strobe_d;
      out_first_q   <= out_first_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      frame_len_q   <= frame_len_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    esc_d   = esc_q;
    held_d  = held_q;
    sum_d   = sum_q;
    count_d = count_q;
    unique case (state_q)
      HUNT: begin
        if (is_flag) begin
          state_d = START;
          esc_d   = 1'b0;
        end
      end
      START: begin
        if (is_flag) begin
          esc_d = 1'b0;
        end else if (is_esc) begin
          esc_d = 1'b1;
        end else if (is_data) begin
          held_d  = dec;
          sum_d   = dec;
          count_d = 8'd1;
          esc_d   = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (is_flag) begin
          esc_d   = 1'b0;
          state_d = START;
        end else if (is_esc) begin
          esc_d = 1'b1;
        end else if (is_data) begin
          esc_d = 1'b0;
          if (count_q == LIMIT) begin
            state_d = HUNT;
          end else begin
            held_d  = dec;
            sum_d   = sum_q + dec;
            count_d = count_q + 8'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // The held byte is released only when a newer byte proves it is not the checksum.
  always_comb begin
    out_data_d    = out_data_q;
    out_strobe_d  = 1'b0;
    out_first_d   = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    frame_len_d   = frame_len_q;
    if (state_q == DATA) begin
      if (is_data) begin
        if (count_q == LIMIT) begin
          frame_error_d = 1'b1;
        end else begin
          out_data_d   = held_q;
          out_strobe_d = 1'b1;
          out_first_d  = (count_q == 8'd1);
        end
      end else if (is_flag) begin
        if (!esc_q && (count_q >= 8'd2) && (sum_q == 8'h00)) begin
          frame_done_d = 1'b1;
          frame_len_d  = count_q - 8'd1;
        end else begin
          frame_error_d = 1'b1;
        end
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_strobe  = out_strobe_q;
  assign out_first   = out_first_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign frame_len   = frame_len_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx (MAX_LEN=4): directed vector table run with and
// without idle gaps, then random framed traffic against a queue-based model.
module tb_serial_frame_rx;

  localparam int MAX_LEN = 4;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_strobe = 1'b0;
  logic [7:0] out_data;
  logic       out_strobe, out_first, frame_done, frame_error;
  logic [7:0] frame_len;

  serial_frame_rx #(.MAX_LEN(MAX_LEN)) dut (
    .mclk       (mclk),
    .reset      (reset),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .out_first  (out_first),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .frame_len  (frame_len)
  );

  always #10 mclk = ~mclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs change on the falling edge, outputs sampled just after the rising edge.
  task automatic drive(input logic r, input logic [7:0] din, input logic stb);
    @(negedge mclk);
    reset     = r;
    in_data   = din;
    in_strobe = stb;
    @(posedge mclk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [7:0] din;
    logic       stb;
    logic [7:0] dout;
    logic       os, of, fd, fe;
    logic [7:0] len;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [7:0] din, input logic stb, input logic [7:0] dout,
                     input logic os, input logic of, input logic fd, input logic fe, input logic [7:0] len);
    vec_t v;
    v.rst = rst; v.din = din; v.stb = stb; v.dout = dout;
    v.os = os; v.of = of; v.fd = fd; v.fe = fe; v.len = len;
    tbl.push_back(v);
  endtask

  task automatic r();                                   add(1, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'd0); endtask
  task automatic b(input logic [7:0] din, input logic [7:0] len); add(0, din, 1, 8'h00, 0, 0, 0, 0, len); endtask
  task automatic o(input logic [7:0] din, input logic [7:0] dout, input logic first, input logic [7:0] len);
    add(0, din, 1, dout, 1, first, 0, 0, len);
  endtask
  task automatic d(input logic [7:0] din, input logic [7:0] len); add(0, din, 1, 8'h00, 0, 0, 1, 0, len); endtask
  task automatic e(input logic [7:0] din, input logic [7:0] len); add(0, din, 1, 8'h00, 0, 0, 0, 1, len); endtask

  task automatic build_table();
    r();
    // good frame
    b(8'h7E, 0); b(8'h01, 0); o(8'h02, 8'h01, 1, 0); o(8'hFD, 8'h02, 0, 0); d(8'h7E, 2);
    // escaped payload
    b(8'h7E, 2); b(8'h7D, 2); b(8'h5E, 2); b(8'h7D, 2); o(8'h5D, 8'h7E, 1, 2); o(8'h05, 8'h7D, 0, 2); d(8'h7E, 2);
    // bad checksum keeps frame_len
    b(8'h7E, 2); b(8'h01, 2); o(8'h02, 8'h01, 1, 2); o(8'h00, 8'h02, 0, 2); e(8'h7E, 2);
    r();
    // leading junk and idle flags
    b(8'h01, 0); b(8'h02, 0); b(8'h7E, 0); b(8'h7E, 0); b(8'h7E, 0); b(8'h10, 0); o(8'hF0, 8'h10, 1, 0); d(8'h7E, 1);
    // overflow at MAX_LEN+2 data bytes, then recovery
    b(8'h7E, 1); b(8'h01, 1); o(8'h02, 8'h01, 1, 1); o(8'h03, 8'h02, 0, 1); o(8'h04, 8'h03, 0, 1);
    o(8'h05, 8'h04, 0, 1); e(8'h06, 1); b(8'h07, 1); b(8'h7E, 1); b(8'h7E, 1); b(8'h10, 1);
    o(8'hF0, 8'h10, 1, 1); d(8'h7E, 1);
    // escape-abort, short frame, ESC+FLAG in START, ESC ESC as one data byte
    b(8'h7E, 1); b(8'h01, 1); b(8'h7D, 1); e(8'h7E, 1);
    b(8'h01, 1); e(8'h7E, 1);
    b(8'h7D, 1); b(8'h7E, 1);
    b(8'h7D, 1); b(8'h7D, 1); e(8'h7E, 1);
    // reset mid-frame is silent and returns to HUNT
    b(8'h01, 1); o(8'h02, 8'h01, 1, 1); r(); b(8'h03, 0); b(8'hFD, 0); b(8'h7E, 0);
  endtask

  task automatic check_vec(input string tag, input vec_t v, input logic gap);
    if (gap) begin
      check({tag, " gap strobe"}, {7'd0, out_strobe}, 8'd0);
      check({tag, " gap done"},   {7'd0, frame_done}, 8'd0);
      check({tag, " gap error"},  {7'd0, frame_error}, 8'd0);
      check({tag, " gap len"},    frame_len, v.len);
    end else begin
      check({tag, " strobe"}, {7'd0, out_strobe}, {7'd0, v.os});
      check({tag, " first"},  {7'd0, out_first}, {7'd0, v.of});
      check({tag, " done"},   {7'd0, frame_done}, {7'd0, v.fd});
      check({tag, " error"},  {7'd0, frame_error}, {7'd0, v.fe});
      check({tag, " len"},    frame_len, v.len);
      if (v.os || v.rst) check({tag, " data"}, out_data, v.dout);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the decoded bytes of the open frame in a queue; the last element is
  // always the checksum candidate.
  bit         m_hunt;
  bit         m_esc;
  byte        m_q[$];
  logic [7:0] e_data, e_len;
  logic       e_os, e_of, e_fd, e_fe;

  task automatic model_step(input logic r, input logic [7:0] din, input logic stb);
    int s;
    logic [7:0] dv;
    e_os = 0; e_of = 0; e_fd = 0; e_fe = 0;
    if (r) begin
      m_hunt = 1; m_esc = 0; m_q.delete();
      e_data = 8'h00; e_len = 8'h00;
      return;
    end
    if (!stb) return;
    if (din == 8'h7E) begin
      if (m_hunt) begin
        m_hunt = 0;
      end else if (m_q.size() > 0) begin
        s = 0;
        foreach (m_q[i]) s += int'(m_q[i]) & 255;
        if (!m_esc && m_q.size() >= 2 && (s % 256) == 0) begin
          e_fd = 1;
          e_len = 8'(m_q.size() - 1);
        end else begin
          e_fe = 1;
        end
      end
      m_q.delete();
      m_esc = 0;
    end else if (m_hunt) begin
      // ignored
    end else if (din == 8'h7D && !m_esc) begin
      m_esc = 1;
    end else begin
      dv = m_esc ? (din ^ 8'h20) : din;
      m_esc = 0;
      if (m_q.size() == MAX_LEN + 1) begin
        e_fe = 1;
        m_hunt = 1;
        m_q.delete();
      end else begin
        if (m_q.size() >= 1) begin
          e_os = 1;
          e_of = (m_q.size() == 1);
          e_data = m_q[m_q.size() - 1];
        end
        m_q.push_back(dv);
      end
    end
  endtask

  task automatic tx(input logic r, input logic [7:0] din, input logic stb);
    drive(r, din, stb);
    model_step(r, din, stb);
    check("rnd strobe", {7'd0, out_strobe}, {7'd0, e_os});
    check("rnd first",  {7'd0, out_first}, {7'd0, e_of});
    check("rnd done",   {7'd0, frame_done}, {7'd0, e_fd});
    check("rnd error",  {7'd0, frame_error}, {7'd0, e_fe});
    check("rnd len",    frame_len, e_len);
    check("rnd data",   out_data, e_data);
  endtask

  task automatic send(input logic [7:0] bv);
    if ($urandom_range(0, 3) == 0) tx(0, 8'($urandom), 0);
    tx(0, bv, 1);
  endtask

  task automatic send_dec(input logic [7:0] dv);
    if (dv == 8'h7E || dv == 8'h7D || $urandom_range(0, 7) == 0) begin
      send(8'h7D);
      send(dv ^ 8'h20);
    end else begin
      send(dv);
    end
  endtask

  task automatic random_frame();
    int kind, plen;
    logic [7:0] pay, sum;
    kind = int'($urandom_range(0, 9));
    if ($urandom_range(0, 39) == 0) tx(1, 8'h00, 0);
    repeat ($urandom_range(0, 2)) send(8'($urandom));
    send(8'h7E);
    plen = int'($urandom_range(0, 6));
    sum = 8'h00;
    for (int i = 0; i < plen; i++) begin
      pay = ($urandom_range(0, 3) == 0) ? 8'h7D + 8'($urandom_range(0, 1)) : 8'($urandom);
      if ($urandom_range(0, 5) == 0) pay = pay ^ 8'h20;
      sum = sum + pay;
      send_dec(pay);
    end
    if (kind != 2) send_dec((kind == 0) ? (8'h01 - sum) : (8'h00 - sum));
    if (kind == 1) send(8'h7D);
    send(8'h7E);
  endtask

  // ---------------- sequencing ----------------
  initial begin
    build_table();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < tbl.size(); i++) begin
        drive(tbl[i].rst, tbl[i].din, tbl[i].stb);
        check_vec($sformatf("vec%0d.%0d", pass, i), tbl[i], 1'b0);
        if (pass == 1) begin
          drive(0, 8'($urandom), 0);
          check_vec($sformatf("vec%0d.%0d", pass, i), tbl[i], 1'b1);
        end
      end
    end

    tx(1, 8'h00, 0);
    tx(1, 8'h00, 0);
    for (int f = 0; f < 400; f++) random_frame();

    drive(0, 8'h00, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
